nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that time-shares one full4Adder (4-bit ripple adder) to add two
//  NIBBLES*4-bit operands, one nibble per cycle, LSB nibble first.
//  Holds the inter-nibble carry in a register. Exposes a start/busy/done handshake.
//  Sits between a host (switch/register interface) and the single adder instance.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices per operand (W = 4*NIBBLES); legal >= 1
// PORTS
//  clk    in   1  single system clock, all state on rising edge
//  rst    in   1  synchronous, active-high reset
//  start  in   1  request; sampled only in IDLE
//  a      in   W  operand A; latched on accepted start
//  b      in   W  operand B; latched on accepted start
//  cin    in   1  carry into nibble 0; latched on accepted start
//  busy   out  1  high while an operation is in progress
//  done   out  1  single-cycle pulse: sum/cout just updated
//  sum    out  W  result; holds the last completed value
//  cout   out  1  carry out of nibble NIBBLES-1; holds the last completed value
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; index, carry and
//    working registers cleared.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, start=1 at edge E0: latch a, b, cin into shift/carry registers.
//    Set idx=0 and state=RUN. busy=1 from the cycle after E0.
//  - RUN, edge Ek (k=1..NIBBLES): the adder sees a_sh[3:0], b_sh[3:0] and the
//    carry register. Its s shifts into the working sum from the MSB side.
//    Its cout loads the carry register. a_sh and b_sh shift right by 4. idx++.
//  - At E_NIBBLES: sum <= completed working sum, cout <= final carry,
//    state=DONE, busy=0, done=1 for exactly one cycle.
//    DONE -> IDLE unconditionally at the next edge.
//  - Latency: done is high in the cycle after the NIBBLES-th edge following E0.
//    Throughput: one operation per NIBBLES+2 cycles.
//  - start during RUN or DONE: ignored, not queued. a, b and cin changes
//    after E0 have no effect.
//  - sum/cout never show partial results. They change only on the done edge
//    or on rst.
//  - Arithmetic: unsigned, modulo 2^W. cout is the carry out of bit W-1.
//  - Terminal index: idx counts to NIBBLES-1; its width is clog2(NIBBLES),
//    with a minimum of 1 bit. NIBBLES=1: exactly one RUN cycle.
//  - rst mid-operation: abort immediately to reset values. No done pulse.
//    sum=0, not the prior result.
//  - rst and start high in the same cycle: rst wins; the start is dropped.
// CONFIGURATION
//  SERIAL_ADD_SUB_EN defined: adds port sub (in, 1), latched with the
//    operands on an accepted start.
//    - sub=1: every b nibble enters the adder inverted; nibble-0 carry is
//      forced to 1 and cin is ignored; result = a - b mod 2^W.
//    - cout=1 means no borrow (a >= b).
//    - sub=0: same as plain addition.
//  Undefined: no sub port; addition only; logic identical to the sub=0 case.
// TESTING  (NIBBLES=4 unless noted)
//  - a=16'h1234, b=16'h4321, cin=0, start pulse -> sum=16'h5555, cout=0.
//    done exactly 4 edges after E0; busy high the 4 preceding cycles.
//  - a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1.
//    The carry ripples through all 4 nibbles.
//  - a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
//    Then a second start with a=16'h0001, b=16'h0002 is pulsed in RUN.
//    It is ignored; sum holds FFFF until a new start is accepted in IDLE.
//  - Start with a=16'h00FF, b=16'h0001, then rst=1 two cycles after E0.
//    -> busy=0, done never pulses, sum=0, cout=0.
//    The next operation completes normally.
//  - NIBBLES=1: a=4'hA, b=4'h5, cin=1 -> sum=4'h0, cout=1; done 1 edge after E0.
//  - SERIAL_ADD_SUB_EN: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0.
//    a=16'h0007, b=16'h0005, sub=1 -> sum=16'h0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two 4*NIBBLES-bit operands one nibble per
// cycle through a single 4-bit ripple adder, LSB nibble first.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   start       request, honoured only when idle
//   a, b, cin   operands and carry-in, latched when start is accepted
//   busy        high while nibbles are being summed
//   done        one-cycle pulse when sum/cout update
//   sum, cout   last completed result, never a partial one
//
// Optional build macro: SERIAL_ADD_SUB_EN adds input 'sub'. When it is
// latched high the result is a - b and cout=1 means no borrow.

module full4Adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  wsum_q;
  logic [W-1:0]  wsum_nx;
  logic [IW-1:0] idx_q;
  logic          carry_q;

  logic          accept;
  logic          step;
  logic          last;

  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic [3:0]    add_s;
  logic          add_co;
  logic          cin_eff;

`ifdef SERIAL_ADD_SUB_EN
  logic          sub_q;

  // Subtraction is a + ~b + 1: invert every b nibble, force carry-in.
  assign add_b   = b_sh[3:0] ^ {4{sub_q}};
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign add_b   = b_sh[3:0];
  assign cin_eff = cin;
`endif

  assign add_a = a_sh[3:0];

  full4Adder u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  // Each nibble result enters from the top; after NIBBLES steps the
  // first nibble has reached bit 0.
  generate
    if (NIBBLES == 1) begin : g_one
      assign wsum_nx = add_s;
    end else begin : g_many
      assign wsum_nx = {add_s, wsum_q[W-1:4]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (idx_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      wsum_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        carry_q <= cin_eff;
        idx_q   <= '0;
        wsum_q  <= '0;
`ifdef SERIAL_ADD_SUB_EN
        sub_q   <= sub;
`endif
      end else if (step) begin
        a_sh    <= a_sh >> 4;
        b_sh    <= b_sh >> 4;
        carry_q <= add_co;
        wsum_q  <= wsum_nx;
        idx_q   <= idx_q + IW'(1);
        if (last) begin
          sum  <= wsum_nx;
          cout <= add_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: vectors, random ops against an arithmetic
// model, and reset/ignored-start sequences for NIBBLES=4 and NIBBLES=1.

module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst;

  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        cin1;
  logic        busy1;
  logic        done1;
  logic [3:0]  sum1;
  logic        cout1;

`ifdef SERIAL_ADD_SUB_EN
  logic        sub;
  logic        sub1;
`endif

  int          errors;
  int          checks;

  logic [15:0] exp_sum;
  logic        exp_cout;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vt[7];

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit operation; the expected result is plain integer arithmetic.
  task automatic do_op(input string nm, input logic [15:0] va,
                       input logic [15:0] vb, input logic vc,
                       input logic vs, input logic poke);
    logic [16:0] full;
    logic [15:0] bb;
    int          cyc;
    logic        bad;
    bb   = vs ? ~vb : vb;
    full = {1'b0, va} + {1'b0, bb} + {16'd0, (vs ? 1'b1 : vc)};
    a     = va;
    b     = vb;
    cin   = vc;
`ifdef SERIAL_ADD_SUB_EN
    sub   = vs;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    cin   = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'($urandom);
`endif
    cyc = 0;
    bad = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1 || sum !== exp_sum || cout !== exp_cout)
        bad = 1'b1;
      if (poke && cyc == 1) begin
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0002;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({nm, " latency"}, cyc, 4);
    chk({nm, " busy/hold during run"}, {31'd0, bad}, 0);
    chk({nm, " busy at done"}, {31'd0, busy}, 0);
    chk({nm, " sum"}, {16'd0, sum}, {16'd0, full[15:0]});
    chk({nm, " cout"}, {31'd0, cout}, {31'd0, full[16]});
    exp_sum  = full[15:0];
    exp_cout = full[16];
    tick();
    chk({nm, " done single pulse"}, {31'd0, done}, 0);
  endtask

  task automatic do_op1(input string nm, input logic [3:0] va,
                        input logic [3:0] vb, input logic vc);
    logic [4:0] full;
    int         cyc;
    full   = {1'b0, va} + {1'b0, vb} + {4'd0, vc};
    a1     = va;
    b1     = vb;
    cin1   = vc;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1     = 4'($urandom);
    b1     = 4'($urandom);
    cyc    = 0;
    while (done1 !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk({nm, " n1 latency"}, cyc, 1);
    chk({nm, " n1 sum"}, {28'd0, sum1}, {28'd0, full[3:0]});
    chk({nm, " n1 cout"}, {31'd0, cout1}, {31'd0, full[4]});
    tick();
    chk({nm, " n1 done pulse"}, {31'd0, done1}, 0);
  endtask

  initial begin
    logic seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    errors = 0;
    checks = 0;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vt[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vt[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub    = 1'b0;
    sub1   = 1'b0;
`endif
    exp_sum  = '0;
    exp_cout = 1'b0;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset sum", {16'd0, sum}, 0);
    chk("reset cout", {31'd0, cout}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin,
            1'b0, 1'b0);
      chk($sformatf("vec%0d table sum", i), {16'd0, sum}, {16'd0, vt[i].s});
      chk($sformatf("vec%0d table cout", i), {31'd0, cout},
          {31'd0, vt[i].co});
    end

    // Start pulsed mid-run must be dropped, not queued.
    do_op("poke", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("poke ignored", {31'd0, seen}, 0);
    chk("poke sum held", {16'd0, sum}, 32'h0000FFFF);

    // Reset in the middle of an operation.
    a     = 16'h00FF;
    b     = 16'h0001;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst busy", {31'd0, busy}, 0);
    chk("midrst done", {31'd0, done}, 0);
    chk("midrst sum", {16'd0, sum}, 0);
    chk("midrst cout", {31'd0, cout}, 0);
    rst      = 1'b0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("midrst no done", {31'd0, seen}, 0);
    do_op("after rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    a     = 16'h0101;
    b     = 16'h0101;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("rst+start dropped", {31'd0, seen}, 0);
    chk("rst+start sum", {16'd0, sum}, 0);

`ifdef SERIAL_ADD_SUB_EN
    do_op("sub5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    chk("sub5-7 sum", {16'd0, sum}, 32'h0000FFFE);
    chk("sub5-7 cout", {31'd0, cout}, 0);
    do_op("sub7-5", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
    chk("sub7-5 sum", {16'd0, sum}, 32'h00000002);
    chk("sub7-5 cout", {31'd0, cout}, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op($sformatf("rand%0d", i), ra, rb, rc, rs, 1'b0);
    end

    do_op1("n1 A+5+1", 4'hA, 4'h5, 1'b1);
    chk("n1 table sum", {28'd0, sum1}, 0);
    chk("n1 table cout", {31'd0, cout1}, 1);
    for (int i = 0; i < 10; i++) begin
      do_op1($sformatf("n1 rand%0d", i), 4'($urandom), 4'($urandom),
             1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
